// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the instruction fetch path and its companions
// (disassembler / trace logic).
//   - opcode constants for control-flow and special instructions
//   - opcode range bounds used by the length table
//   - fetch FSM state encoding
//   - instr_length(): opcode -> instruction length in bytes (1..3)
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Special opcodes
    localparam logic [7:0] OP_HALT = 8'hFF;
    localparam logic [7:0] OP_NOP  = 8'hFC;
    localparam logic [7:0] OP_RET  = 8'hFB;
    localparam logic [7:0] OP_CALL = 8'hF9;
    localparam logic [7:0] OP_JMP  = 8'hF8;

    // Opcode ranges that carry trailing bytes
    localparam logic [7:0] ALU_IMM_LO = 8'h80;  // ALU immediate, 2 bytes
    localparam logic [7:0] ALU_IMM_HI = 8'h87;
    localparam logic [7:0] MOVI_LO    = 8'hB8;  // MOVI, 2 bytes
    localparam logic [7:0] MOVI_HI    = 8'hBF;
    localparam logic [7:0] JCC_LO     = 8'hE0;  // conditional jump, 3 bytes
    localparam logic [7:0] JCC_HI     = 8'hEF;

    // Fetch FSM state encoding
    typedef logic [2:0] fetch_state_t;
    localparam fetch_state_t ST_FETCH_OP = 3'd0;
    localparam fetch_state_t ST_FETCH_B1 = 3'd1;
    localparam fetch_state_t ST_FETCH_B2 = 3'd2;
    localparam fetch_state_t ST_PRESENT  = 3'd3;
    localparam fetch_state_t ST_HALTED   = 3'd4;

    // Instruction length in bytes for a given opcode
    function automatic logic [1:0] instr_length(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if ((op >= ALU_IMM_LO && op <= ALU_IMM_HI) ||
            (op >= MOVI_LO    && op <= MOVI_HI)) begin
            len = 2'd2;
        end else if ((op >= JCC_LO && op <= JCC_HI) ||
                     (op == OP_JMP) || (op == OP_CALL)) begin
            len = 2'd3;
        end
        return len;
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// -----------------------------------------------------------------------------
// instr_len_decode
// Purely combinational opcode-to-length decoder.
//   opcode    in  8  opcode byte
//   instr_len out 2  instruction length in bytes: 1, 2 or 3
// -----------------------------------------------------------------------------
module instr_len_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] instr_len
);

    assign instr_len = instr_length(opcode);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Drives the byte-wide memory read address, assembles variable-length
// instructions (opcode + 0..2 trailing bytes) and presents each whole
// instruction to decode/execute over a valid/ready handshake. Supports PC
// redirect (jump/call/return) and stops fetching after HALT is accepted.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   mem_addr       read address to memory (always the internal PC)
//   mem_dout       combinational read data at mem_addr
//   pc_load        redirect request from execute (highest priority)
//   pc_load_val    redirect target
//   instr_valid    complete instruction presented
//   instr_ready    consumer accepts the instruction this cycle
//   opcode         opcode byte
//   operand        len 2: {8'h00, b1}; len 3: {b1, b2}; len 1: 0
//   instr_len      instruction length 1..3
//   instr_pc       address of the opcode byte
//   next_pc        instr_pc + instr_len (CALL return address)
//   halted         HALT accepted, fetching stopped
//
// Configuration macro:
//   FETCH_SKIP_NOP_EN  when defined, NOP (8'hFC) opcodes are consumed in
//                      FETCH_OP without being presented (1 cycle each).
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        opcode,
    output logic [15:0]       operand,
    output logic [1:0]        instr_len,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              halted
);

    fetch_state_t      state_q,     state_d;
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [7:0]        opcode_q,    opcode_d;
    logic [15:0]       operand_q,   operand_d;
    logic [1:0]        instr_len_q, instr_len_d;
    logic [ADDR_W-1:0] instr_pc_q,  instr_pc_d;
    logic [ADDR_W-1:0] next_pc_q,   next_pc_d;

    logic [1:0]        dec_len;
    logic              skip_nop;
    logic [ADDR_W-1:0] pc_inc;

    // Length of the byte currently on the memory bus; only meaningful
    // while that byte is an opcode (FETCH_OP).
    instr_len_decode u_len_dec (
        .opcode    (mem_dout),
        .instr_len (dec_len)
    );

`ifdef FETCH_SKIP_NOP_EN
    assign skip_nop = (mem_dout == OP_NOP);
`else
    assign skip_nop = 1'b0;
`endif

    // Modulo 2^ADDR_W increment; wraps naturally at the top of memory.
    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        instr_len_d = instr_len_q;
        instr_pc_d  = instr_pc_q;
        next_pc_d   = next_pc_q;

        case (state_q)
            ST_FETCH_OP: begin
                pc_d = pc_inc;
                if (!skip_nop) begin
                    opcode_d    = mem_dout;
                    instr_len_d = dec_len;
                    instr_pc_d  = pc_q;
                    next_pc_d   = pc_q + ADDR_W'(dec_len);
                    operand_d   = '0;
                    state_d     = (dec_len == 2'd1) ? ST_PRESENT : ST_FETCH_B1;
                end
            end
            ST_FETCH_B1: begin
                pc_d = pc_inc;
                // b1 lands in the high byte for 3-byte forms, low byte otherwise
                if (instr_len_q == 2'd3) begin
                    operand_d = {mem_dout, 8'h00};
                    state_d   = ST_FETCH_B2;
                end else begin
                    operand_d = {8'h00, mem_dout};
                    state_d   = ST_PRESENT;
                end
            end
            ST_FETCH_B2: begin
                pc_d      = pc_inc;
                operand_d = {operand_q[15:8], mem_dout};
                state_d   = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (instr_ready) begin
                    state_d = (opcode_q == OP_HALT) ? ST_HALTED : ST_FETCH_OP;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH_OP;
            end
        endcase

        // Redirect overrides every state; a coincident handshake in PRESENT
        // still counts as accepted, only the next fetch address changes.
        if (pc_load) begin
            pc_d    = pc_load_val;
            state_d = ST_FETCH_OP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH_OP;
            pc_q        <= RESET_PC;
            opcode_q    <= '0;
            operand_q   <= '0;
            instr_len_q <= '0;
            instr_pc_q  <= '0;
            next_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            instr_len_q <= instr_len_d;
            instr_pc_q  <= instr_pc_d;
            next_pc_q   <= next_pc_d;
        end
    end

    assign mem_addr    = pc_q;
    assign instr_valid = (state_q == ST_PRESENT);
    assign halted      = (state_q == ST_HALTED);
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign instr_len   = instr_len_q;
    assign instr_pc    = instr_pc_q;
    assign next_pc     = next_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Scoreboard bench: a memory-walking reference model pushes the expected
// instruction stream into a queue; a monitor compares every presented
// instruction against the queue head and pops on each handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic [15:0] next_pc;
    logic        halted;

    logic [7:0]  mem [0:65535];
    assign mem_dout = mem[mem_addr];

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .instr_len   (instr_len),
        .instr_pc    (instr_pc),
        .next_pc     (next_pc),
        .halted      (halted)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] operand;
        logic [1:0]  len;
        logic [15:0] pc;
        logic [15:0] nxt;
    } instr_t;

    instr_t exp_q[$];
    instr_t mon_got;
    instr_t mon_want;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     ready_mode = 0;  // 0: always ready, 1: random, 2: driven by hand

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Instruction length straight from the opcode table
    function automatic int ref_len(input logic [7:0] op);
        if (op inside {[8'h80:8'h87], [8'hB8:8'hBF]}) return 2;
        if (op inside {[8'hE0:8'hEF], 8'hF8, 8'hF9}) return 3;
        return 1;
    endfunction

    // Walk memory from start, queue every instruction up to and including HALT
    task automatic model_walk(input logic [15:0] start, output logic [15:0] end_pc);
        logic [15:0] pc;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [7:0]  op;
        int          len;
        instr_t      e;
        pc = start;
        for (int n = 0; n < 200; n++) begin
            op = mem[pc];
`ifdef FETCH_SKIP_NOP_EN
            if (op == 8'hFC) begin
                pc = pc + 16'd1;
                continue;
            end
`endif
            len = ref_len(op);
            a1  = pc + 16'd1;
            a2  = pc + 16'd2;
            e.op  = op;
            e.len = 2'(len);
            e.pc  = pc;
            case (len)
                3:       e.operand = {mem[a1], mem[a2]};
                2:       e.operand = {8'h00, mem[a1]};
                default: e.operand = 16'h0000;
            endcase
            pc    = pc + 16'(len);
            e.nxt = pc;
            exp_q.push_back(e);
            if (op == 8'hFF) break;
        end
        end_pc = pc;
    endtask

    // Monitor: compare presented instruction with queue head, pop on handshake
    always @(negedge clk) begin
        if (rst === 1'b0 && instr_valid === 1'b1) begin
            mon_got = {opcode, operand, instr_len, instr_pc, next_pc};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_instr: got op=%h pc=%h, required no instruction",
                         opcode, instr_pc);
            end else begin
                mon_want = exp_q[0];
                if (mon_got !== mon_want) begin
                    n_fail++;
                    $display("FAIL instr: got op=%h opnd=%h len=%0d pc=%h nxt=%h, required op=%h opnd=%h len=%0d pc=%h nxt=%h",
                             mon_got.op, mon_got.operand, mon_got.len, mon_got.pc, mon_got.nxt,
                             mon_want.op, mon_want.operand, mon_want.len, mon_want.pc, mon_want.nxt);
                end
                if (instr_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic update_ready();
        if (ready_mode == 0)      instr_ready = 1'b1;
        else if (ready_mode == 1) instr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        update_ready();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},   32'(instr_valid), 32'd0);
        check({tag, "_halted"},  32'(halted),      32'd0);
        check({tag, "_addr"},    32'(mem_addr),    32'h0000);
        check({tag, "_opcode"},  32'(opcode),      32'd0);
        check({tag, "_operand"}, 32'(operand),     32'd0);
        check({tag, "_len"},     32'(instr_len),   32'd0);
        check({tag, "_ipc"},     32'(instr_pc),    32'd0);
        check({tag, "_npc"},     32'(next_pc),     32'd0);
    endtask

    // Hold reset, check reset outputs, release just after an edge;
    // the next rising edge performs the first opcode fetch.
    task automatic start_from_reset();
        rst     = 1'b1;
        pc_load = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget, input logic [15:0] end_pc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && halted === 1'b1) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            update_ready();
        end
        check({name, "_complete"}, 32'(done), 32'd1);
        if (!done) exp_q.delete();
        check({name, "_halted"}, 32'(halted),      32'd1);
        check({name, "_pc"},     32'(mem_addr),    32'(end_pc));
        check({name, "_valid"},  32'(instr_valid), 32'd0);
    endtask

    task automatic redirect(input logic [15:0] target);
        tick();
        pc_load     = 1'b1;
        pc_load_val = target;
        tick();
        pc_load = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] endp;
        logic [15:0] base;
        logic [15:0] a;
        logic [7:0]  op;
        int          k;
        bit          seen;

        rst         = 1'b1;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        instr_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        // Basic stream: MOVI, CALL, HALT
        mem[0] = 8'hBB; mem[1] = 8'h05; mem[2] = 8'hF9;
        mem[3] = 8'h02; mem[4] = 8'h00; mem[5] = 8'hFF;
        ready_mode = 0;
        model_walk(16'h0000, endp);
        start_from_reset();
        drain("basic", 100, endp);

        // Backpressure on a 2-byte instruction
        mem[0] = 8'hB9; mem[1] = 8'h01; mem[2] = 8'hFF;
        ready_mode  = 2;
        instr_ready = 1'b0;
        model_walk(16'h0000, endp);
        start_from_reset();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(instr_valid), 32'd1);
            check("bp_hold_pc",    32'(mem_addr),    32'h0002);
            @(posedge clk);
            #1;
        end
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        @(negedge clk);
        check("bp_after_accept_valid", 32'(instr_valid), 32'd0);
        check("bp_next_fetch_addr",    32'(mem_addr),    32'h0002);
        ready_mode = 0;
        drain("bp", 100, endp);

        // Redirect during FETCH_B1 of a 3-byte conditional jump
        mem[0] = 8'hE8; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'hFF;
        mem[16'h0200] = 8'h3C; mem[16'h0201] = 8'hFF;
        ready_mode = 0;
        start_from_reset();
        tick();                       // opcode E8 fetched on this edge
        pc_load     = 1'b1;
        pc_load_val = 16'h0200;
        model_walk(16'h0200, endp);
        tick();                       // redirect taken instead of b1
        pc_load = 1'b0;
        @(negedge clk);
        check("redir_valid", 32'(instr_valid), 32'd0);
        check("redir_addr",  32'(mem_addr),    32'h0200);
        drain("redir", 100, endp);

        // pc_load while halted, into a 2-byte instruction that wraps
        mem[16'hFFFF] = 8'hBB; mem[16'h0000] = 8'h07; mem[16'h0001] = 8'hFF;
        model_walk(16'hFFFF, endp);
        redirect(16'hFFFF);
        @(negedge clk);
        check("resume_halted", 32'(halted),   32'd0);
        check("resume_addr",   32'(mem_addr), 32'hFFFF);
        drain("wrap", 100, endp);

        // Reset in the middle of a 3-byte instruction (during FETCH_B2)
        mem[0] = 8'hE8; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'hFF;
        start_from_reset();
        tick();                       // FETCH_OP
        tick();                       // FETCH_B1
        rst = 1'b1;
        tick();                       // reset replaces FETCH_B2
        @(negedge clk);
        check_reset_state("midrst");
        mem[0] = 8'h3C; mem[1] = 8'hFF;
        model_walk(16'h0000, endp);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain("midrst", 100, endp);

        // NOP handling
        mem[0] = 8'hFC; mem[1] = 8'hFC; mem[2] = 8'hFB; mem[3] = 8'hFF;
        model_walk(16'h0000, endp);
        start_from_reset();
        drain("nop", 100, endp);

        // Random programs under random backpressure, entered via redirect
        ready_mode = 1;
        for (int r = 0; r < 8; r++) begin
            base = (r == 0) ? 16'hFFF9 : 16'($urandom);
            a    = base;
            k    = $urandom_range(4, 12);
            for (int j = 0; j < k; j++) begin
                op = 8'($urandom);
                if (op == 8'hFF) op = 8'h00;
                mem[a] = op;
                a = a + 16'd1;
                for (int b = 1; b < ref_len(op); b++) begin
                    mem[a] = 8'($urandom);
                    a = a + 16'd1;
                end
            end
            mem[a] = 8'hFF;
            model_walk(base, endp);
            redirect(base);
            drain("rand", 400, endp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sits directly upstream of the byte-wide program/data memory; drives its read address and consumes its combinational read data.
- Assembles variable-length instructions (opcode plus 0–2 trailing bytes) and presents each whole instruction to the decode/execute stage through a valid/ready handshake.
- Supports PC redirect for jump, call and return, and stops fetching after HALT.

Parameters:
- ADDR_W, 16, memory address width in bits.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR_W  read address to memory; always equals the internal PC.
- mem_dout  in  8  combinational read data from memory at mem_addr.
- pc_load  in  1  redirect request from execute.
- pc_load_val  in  ADDR_W  redirect target.
- instr_valid  out  1  a complete instruction is presented.
- instr_ready  in  1  the consumer accepts the instruction this cycle.
- opcode  out  8  opcode byte.
- operand  out  16  trailing bytes. Length 2: {8'h00, b1}. Length 3: {b1, b2} (high byte first). Length 1: 0.
- instr_len  out  2  instruction length: 1, 2 or 3.
- instr_pc  out  ADDR_W  address of the opcode byte.
- next_pc  out  ADDR_W  instr_pc + instr_len, used as the CALL return address.
- halted  out  1  HALT has been accepted; fetching is stopped.

Behaviour:
- Reset: the reset condition applies at any time, including mid-instruction, and the partial instruction is discarded.
  - PC = RESET_PC; state = FETCH_OP.
  - instr_valid, halted, opcode, operand, instr_len, instr_pc and next_pc are all 0.
- Length table (combinational function of the opcode):
  - 2 bytes: 8'h80–8'h87 (ALU immediate), 8'hB8–8'hBF (MOVI).
  - 3 bytes: 8'hE0–8'hEF (conditional jump), 8'hF8 (JMP), 8'hF9 (CALL).
  - 1 byte: every other opcode, including 8'hFB (RET), 8'hFC (NOP) and 8'hFF (HALT).
- FSM states: FETCH_OP, FETCH_B1, FETCH_B2, PRESENT, HALTED.
  - FETCH_OP: sample mem_dout into opcode, capture instr_pc = PC, PC += 1. Go to FETCH_B1 if length > 1, otherwise PRESENT.
  - FETCH_B1: sample b1, PC += 1. Go to FETCH_B2 if length == 3, otherwise PRESENT.
  - FETCH_B2: sample b2, PC += 1, go to PRESENT.
  - PRESENT: instr_valid = 1; all instruction outputs are stable until the handshake completes. On instr_valid & instr_ready: go to HALTED if opcode == 8'hFF, otherwise FETCH_OP. The next opcode fetch starts the cycle after acceptance; there is no prefetch.
  - HALTED: instr_valid = 0, halted = 1, PC frozen. Only pc_load or rst leaves this state.
- Latency from entering FETCH_OP to instr_valid: 1 cycle for 1-byte instructions, 2 cycles for 2-byte, 3 cycles for 3-byte.
- pc_load has the highest priority in every state: PC = pc_load_val, state = FETCH_OP, instr_valid = 0 next cycle, halted cleared.
  - Any partially assembled instruction is flushed.
  - If pc_load coincides with a handshake in PRESENT, the handshake still counts as accepted, and the redirect wins for the next fetch.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF + 1 wraps to 16'h0000, including inside a multi-byte instruction. next_pc wraps the same way.
- The unit never writes memory; the memory write enable is owned by execute.

Optional Feature:
- Macro: FETCH_SKIP_NOP_EN.
- Defined: an 8'hFC opcode sampled in FETCH_OP is consumed silently. PC += 1, state stays FETCH_OP, and no instruction is presented, costing 1 cycle per NOP.
- Undefined: 8'hFC is presented as a normal 1-byte instruction.

Decomposition:
- Shared package (cpu_pkg) holds:
  - opcode constants OP_HALT = 8'hFF, OP_NOP = 8'hFC, OP_RET = 8'hFB, OP_CALL = 8'hF9, OP_JMP = 8'hF8;
  - the opcode-range bounds;
  - the FSM state enum;
  - the function instr_length(opcode) returning 2 bits.
- One natural sub-module, instr_len_decode: a purely combinational opcode-to-length decoder, shared later with the disassembler/trace logic.

Test Plan:
- Memory 0000: BB 05 F9 02 00 FF, instr_ready held at 1 -> three instructions presented in order:
  - {BB, 0005, len 2, pc 0000, next 0002};
  - {F9, 0200, len 3, pc 0002, next 0005};
  - {FF, len 1, pc 0005}, after which halted = 1 and mem_addr stays 0006.
- Backpressure: instr_ready = 0 for 5 cycles while presenting {B9, 0001} -> all outputs stable, PC = 0002 held, then one acceptance and the next fetch at 0002.
- Redirect: pc_load = 1 with pc_load_val = 0200 during FETCH_B1 of E8 02 04 -> partial instruction dropped, next presented instr_pc = 0200 with opcode = memory[0200].
- Wrap: opcode BB at FFFF, 07 at 0000 -> presented {BB, 0007, pc FFFF, next 0001}.
- Reset mid-instruction: rst asserted during FETCH_B2 -> next cycle instr_valid = 0, mem_addr = RESET_PC, halted = 0. Also: pc_load while HALTED -> fetch resumes from the target.
- NOP handling: memory FC FC FB -> with FETCH_SKIP_NOP_EN, the only instruction presented is FB at pc 0002. Without the macro, FC, FC and FB are presented in order.
